// File: rtl/fp_add_sequencer_if.sv
// Command, memory and adder bus of the FP add sequencer.
// slave = sequencer side, master = environment side (issuer, memory, adder).
interface fp_add_sequencer_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_src_a;
   logic [ADDR_W-1:0] cmd_src_b;
   logic [ADDR_W-1:0] cmd_dst;
   logic [ADDR_W-1:0] cmd_exp;
   logic              mem_we;
   logic              mem_mode;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic [DATA_W-1:0] add_a;
   logic [DATA_W-1:0] add_b;
   logic [DATA_W-1:0] add_sum;

   modport slave (
      input  cmd_valid, cmd_src_a, cmd_src_b, cmd_dst, cmd_exp, mem_rdata, add_sum,
      output cmd_ready, mem_we, mem_mode, mem_addr, mem_wdata, add_a, add_b
   );

   modport master (
      output cmd_valid, cmd_src_a, cmd_src_b, cmd_dst, cmd_exp, mem_rdata, add_sum,
      input  cmd_ready, mem_we, mem_mode, mem_addr, mem_wdata, add_a, add_b
   );
endinterface

// File: rtl/fp_add_sequencer.sv
// Sequences read A, read B, external FP add and writeback over a shared memory port.
// Optional result check against a stored word is enabled by defining FPSEQ_CHECK_EN.
module fp_add_sequencer #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   fp_add_sequencer_if.slave   bus,
   output logic                done,
   output logic [DATA_W-1:0]   result,
   output logic                match,
   output logic [15:0]         op_count
);
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RD_A  = 3'd1,
      S_RD_B  = 3'd2,
      S_CAP_B = 3'd3,
      S_ADD   = 3'd4,
      S_WB    = 3'd5,
      S_DONE  = 3'd6
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] src_a_q, src_a_d, src_b_q, src_b_d, dst_q, dst_d;
   logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d, sum_q, sum_d, result_q, result_d;
   logic [15:0]       op_count_q, op_count_d;
   logic              match_q, match_d, done_q, done_d, cmd_ready_q, cmd_ready_d;
   logic              mem_we_q, mem_we_d, mem_mode_q, mem_mode_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              accept_s;
`ifdef FPSEQ_CHECK_EN
   logic [ADDR_W-1:0] exp_addr_q, exp_addr_d;
   logic [DATA_W-1:0] expected_q, expected_d;
`else
   logic              unused_cmd_exp_s;
   assign unused_cmd_exp_s = ^bus.cmd_exp;
`endif

   assign accept_s = bus.cmd_valid && (state_q == S_IDLE);

   // Next-state logic: fixed walk through the operation states.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept_s) state_d = S_RD_A;
            else          state_d = S_IDLE;
         end
         S_RD_A:  state_d = S_RD_B;
         S_RD_B:  state_d = S_CAP_B;
         S_CAP_B: state_d = S_ADD;
         S_ADD:   state_d = S_WB;
         S_WB:    state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath captures: read data arrives one cycle after its address.
   always_comb begin
      src_a_d    = accept_s ? bus.cmd_src_a : src_a_q;
      src_b_d    = accept_s ? bus.cmd_src_b : src_b_q;
      dst_d      = accept_s ? bus.cmd_dst   : dst_q;
      op_a_d     = (state_q == S_RD_B)  ? bus.mem_rdata : op_a_q;
      op_b_d     = (state_q == S_CAP_B) ? bus.mem_rdata : op_b_q;
      sum_d      = (state_q == S_ADD)   ? bus.add_sum   : sum_q;
      result_d   = (state_q == S_DONE)  ? sum_q         : result_q;
      op_count_d = (state_q == S_DONE)  ? op_count_q + 16'd1 : op_count_q;
`ifdef FPSEQ_CHECK_EN
      exp_addr_d = accept_s ? bus.cmd_exp : exp_addr_q;
      expected_d = (state_q == S_ADD)  ? bus.mem_rdata : expected_q;
      match_d    = (state_q == S_DONE) ? (sum_q == expected_q) : match_q;
`else
      match_d    = 1'b0;
`endif
   end

   // Output decode from the next state so every bus output leaves a flop.
   always_comb begin
      mem_we_d    = 1'b0;
      mem_mode_d  = 1'b1;
      mem_addr_d  = {ADDR_W{1'b0}};
      mem_wdata_d = {DATA_W{1'b0}};
      case (state_d)
         S_RD_A: mem_addr_d = src_a_d;
         S_RD_B: mem_addr_d = src_b_d;
`ifdef FPSEQ_CHECK_EN
         S_CAP_B: mem_addr_d = exp_addr_d;
`else
         S_CAP_B: mem_addr_d = {ADDR_W{1'b0}};
`endif
         S_WB: begin
            mem_we_d    = 1'b1;
            mem_mode_d  = 1'b0;
            mem_addr_d  = dst_d;
            mem_wdata_d = sum_d;
         end
         default: mem_addr_d = {ADDR_W{1'b0}};
      endcase
      done_d      = (state_d == S_DONE);
      cmd_ready_d = (state_d == S_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         src_a_q     <= {ADDR_W{1'b0}};
         src_b_q     <= {ADDR_W{1'b0}};
         dst_q       <= {ADDR_W{1'b0}};
         op_a_q      <= {DATA_W{1'b0}};
         op_b_q      <= {DATA_W{1'b0}};
         sum_q       <= {DATA_W{1'b0}};
         result_q    <= {DATA_W{1'b0}};
         op_count_q  <= 16'd0;
         match_q     <= 1'b0;
         done_q      <= 1'b0;
         cmd_ready_q <= 1'b1;
         mem_we_q    <= 1'b0;
         mem_mode_q  <= 1'b1;
         mem_addr_q  <= {ADDR_W{1'b0}};
         mem_wdata_q <= {DATA_W{1'b0}};
`ifdef FPSEQ_CHECK_EN
         exp_addr_q  <= {ADDR_W{1'b0}};
         expected_q  <= {DATA_W{1'b0}};
`endif
      end else begin
         state_q     <= state_d;
         src_a_q     <= src_a_d;
         src_b_q     <= src_b_d;
         dst_q       <= dst_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         sum_q       <= sum_d;
         result_q    <= result_d;
         op_count_q  <= op_count_d;
         match_q     <= match_d;
         done_q      <= done_d;
         cmd_ready_q <= cmd_ready_d;
         mem_we_q    <= mem_we_d;
         mem_mode_q  <= mem_mode_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
`ifdef FPSEQ_CHECK_EN
         exp_addr_q  <= exp_addr_d;
         expected_q  <= expected_d;
`endif
      end
   end

   assign bus.cmd_ready = cmd_ready_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_mode  = mem_mode_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.add_a     = op_a_q;
   assign bus.add_b     = op_b_q;
   assign done          = done_q;
   assign result        = result_q;
   assign match         = match_q;
   assign op_count      = op_count_q;
endmodule

// File: tb/tb_fp_add_sequencer.sv
// Random and directed bench for fp_add_sequencer against a per-command reference model.
// Memory and adder (integer sum stand-in for the FP adder) are modelled here.
module tb_fp_add_sequencer;
   localparam int AW = 5;
   localparam int DW = 32;

   logic           clk = 1'b0;
   logic           reset;
   logic           done, match;
   logic [DW-1:0]  result;
   logic [15:0]    op_count;

   fp_add_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   fp_add_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .done     (done),
      .result   (result),
      .match    (match),
      .op_count (op_count)
   );

   always #5 clk = ~clk;

   logic [31:0] mem     [32];
   logic [31:0] ref_mem [32];
   logic        ld_en;
   logic [4:0]  ld_addr;
   logic [31:0] ld_data;
   int          n_checks = 0;
   int          n_err = 0;
   int          we_cnt = 0;
   logic [4:0]  last_waddr;
   logic [31:0] last_wdata;
   logic        last_wmode;
   logic [15:0] exp_cnt;

   assign bus.add_sum = bus.add_a + bus.add_b;

   // Environment memory: registered read, write on mem_we, bench preload port.
   always @(posedge clk) begin
      if (ld_en) mem[ld_addr] <= ld_data;
      else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_mode) bus.mem_rdata <= mem[bus.mem_addr];
   end

   // Write-pulse monitor.
   always @(negedge clk) begin
      if (bus.mem_we) begin
         we_cnt     <= we_cnt + 1;
         last_waddr <= bus.mem_addr;
         last_wdata <= bus.mem_wdata;
         last_wmode <= bus.mem_mode;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic mem_load(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      @(negedge clk);
      ld_en = 1'b0;
      ref_mem[a] = d;
   endtask

   task automatic run_cmd(input logic [4:0] sa, input logic [4:0] sb,
                          input logic [4:0] dst, input logic [4:0] ex);
      logic [31:0] a, b, s, exv;
      logic        exp_m;
      int          tries, done_at, done_cnt, we0;
      a = ref_mem[sa]; b = ref_mem[sb]; s = a + b; exv = ref_mem[ex];
`ifdef FPSEQ_CHECK_EN
      exp_m = (s == exv);
`else
      exp_m = 1'b0;
`endif
      ref_mem[dst] = s;
      exp_cnt = exp_cnt + 16'd1;
      @(negedge clk);
      tries = 0;
      while (!bus.cmd_ready && tries < 20) begin
         @(negedge clk);
         tries++;
      end
      chk("cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
      bus.cmd_valid = 1'b1; bus.cmd_src_a = sa; bus.cmd_src_b = sb;
      bus.cmd_dst = dst; bus.cmd_exp = ex;
      we0 = we_cnt; done_at = 0; done_cnt = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) bus.cmd_valid = 1'b0;
         if (done) begin
            done_cnt++;
            if (done_at == 0) done_at = k;
         end
         if (k == 6) begin
            chk("add_a", bus.add_a, a);
            chk("add_b", bus.add_b, b);
         end
      end
      chk("done_latency", done_at, 32'd6);
      chk("done_pulses", done_cnt, 32'd1);
      chk("we_pulses", we_cnt - we0, 32'd1);
      chk("wb_addr", {27'd0, last_waddr}, {27'd0, dst});
      chk("wb_data", last_wdata, s);
      chk("wb_mode", {31'd0, last_wmode}, 32'd0);
      chk("mem_dst", mem[dst], s);
      chk("result", result, s);
      chk("match", {31'd0, match}, {31'd0, exp_m});
      chk("op_count", {16'd0, op_count}, {16'd0, exp_cnt});
      chk("idle_bus", {bus.mem_we, bus.mem_mode, 3'd0, bus.mem_addr, 22'd0},
          {1'b0, 1'b1, 3'd0, 5'd0, 22'd0});
      chk("idle_wdata", bus.mem_wdata, 32'd0);
   endtask

   initial begin
      int hs;
      int hs_at [4];
      int we0;
      int saw_done;
      logic [31:0] s;
      reset = 1'b1; ld_en = 1'b0; ld_addr = 5'd0; ld_data = 32'd0;
      bus.cmd_valid = 1'b0; bus.cmd_src_a = 5'd0; bus.cmd_src_b = 5'd0;
      bus.cmd_dst = 5'd0; bus.cmd_exp = 5'd0;
      exp_cnt = 16'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
      chk("rst_flags", {29'd0, done, match, bus.mem_we}, 32'd0);
      chk("rst_mode", {31'd0, bus.mem_mode}, 32'd1);
      chk("rst_addr", {27'd0, bus.mem_addr}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_op_count", {16'd0, op_count}, 32'd0);
      chk("rst_ops", bus.add_a | bus.add_b, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", {31'd0, bus.cmd_ready}, 32'd1);

      for (int i = 0; i < 32; i++) mem_load(i[4:0], $urandom());

      mem_load(5'd22, 32'h40B60001);
      mem_load(5'd28, 32'h40B2041B);
      run_cmd(5'd22, 5'd28, 5'd5, 5'd31);

      mem_load(5'd28, 32'h4134020E - 32'h40B60001);
      mem_load(5'd31, 32'h4134020E);
      run_cmd(5'd22, 5'd28, 5'd9, 5'd31);
      mem_load(5'd31, 32'h00000000);
      run_cmd(5'd22, 5'd28, 5'd9, 5'd31);

      mem_load(5'd7, 32'h3F800000);
      run_cmd(5'd7, 5'd7, 5'd7, 5'd7);
      run_cmd(5'd3, 5'd8, 5'd3, 5'd0);

      for (int i = 0; i < 12; i++)
         run_cmd(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));

      // cmd_valid held for 20 cycles: exactly three handshakes, 7 cycles apart
      s = ref_mem[3] + ref_mem[4];
      ref_mem[6] = s;
      hs = 0;
      bus.cmd_valid = 1'b1; bus.cmd_src_a = 5'd3; bus.cmd_src_b = 5'd4;
      bus.cmd_dst = 5'd6; bus.cmd_exp = 5'd3;
      for (int i = 0; i < 20; i++) begin
         if (bus.cmd_ready && hs < 4) begin
            hs_at[hs] = i;
            hs++;
         end
         @(negedge clk);
      end
      bus.cmd_valid = 1'b0;
      repeat (10) @(negedge clk);
      exp_cnt = exp_cnt + 16'd3;
      chk("hold_handshakes", hs, 32'd3);
      if (hs >= 3) begin
         chk("hold_gap1", hs_at[1] - hs_at[0], 32'd7);
         chk("hold_gap2", hs_at[2] - hs_at[0], 32'd14);
      end
      chk("hold_op_count", {16'd0, op_count}, {16'd0, exp_cnt});
      chk("hold_mem", mem[6], s);

      // reset while in ADD aborts the operation
      we0 = we_cnt; saw_done = 0;
      bus.cmd_valid = 1'b1; bus.cmd_src_a = 5'd1; bus.cmd_src_b = 5'd2;
      bus.cmd_dst = 5'd12; bus.cmd_exp = 5'd0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1) bus.cmd_valid = 1'b0;
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_we", {31'd0, bus.mem_we}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_op_count", {16'd0, op_count}, 32'd0);
      @(negedge clk);
      chk("abort_ready", {31'd0, bus.cmd_ready}, 32'd1);
      for (int k = 0; k < 8; k++) begin
         if (done) saw_done = 1;
         @(negedge clk);
      end
      chk("abort_no_done", saw_done, 32'd0);
      chk("abort_no_we", we_cnt - we0, 32'd0);
      chk("abort_mem", mem[12], ref_mem[12]);
      exp_cnt = 16'd0;

      // op_count wrap from 0xFFFF
      @(negedge clk);
      force dut.op_count_q = 16'hFFFF;
      @(posedge clk);
      #1 release dut.op_count_q;
      @(negedge clk);
      chk("preset_count", {16'd0, op_count}, 32'h0000FFFF);
      exp_cnt = 16'hFFFF;
      run_cmd(5'd10, 5'd11, 5'd13, 5'd14);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/fp_add_sequencer.md
FP_ADD_SEQUENCER -- requirements
Module: fp_add_sequencer

Interface
REQ-001 SHALL have parameter: ADDR_W, 5, register-file address width (32 entries).
REQ-002 SHALL have parameter: DATA_W, 32, word width (IEEE-754 single).
REQ-003 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: cmd_valid  input  1  command request.
REQ-006 SHALL have port: cmd_ready  output  1  sequencer can accept a command.
REQ-007 SHALL have port: cmd_src_a / cmd_src_b / cmd_dst  input  ADDR_W each  operand and destination addresses.
REQ-008 SHALL have port: cmd_exp  input  ADDR_W  address of expected-result word (check feature only).
REQ-009 SHALL have port: mem_we  output  1  memory write enable.
REQ-010 SHALL have port: mem_mode  output  1  memory mode, 0 = write, 1 = read.
REQ-011 SHALL have port: mem_addr  output  ADDR_W  memory address.
REQ-012 SHALL have port: mem_wdata  output  DATA_W  memory write data.
REQ-013 SHALL have port: mem_rdata  input  DATA_W  memory read data, valid one cycle after address presented with mem_mode=1.
REQ-014 SHALL have port: add_a / add_b  output  DATA_W each  operands to external combinational FP adder.
REQ-015 SHALL have port: add_sum  input  DATA_W  adder result.
REQ-016 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-017 SHALL have port: result  output  DATA_W  last written sum.
REQ-018 SHALL have port: match  output  1  last sum equalled expected word.
REQ-019 SHALL have port: op_count  output  16  completed-operation counter.

Function
REQ-020 SHALL implement FSM IDLE -> RD_A -> RD_B -> CAP_B -> ADD -> WB -> DONE -> IDLE, one cycle per non-IDLE state.
REQ-021 SHALL assert cmd_ready only in IDLE; handshake = cmd_valid & cmd_ready at rising edge, latching all command addresses.
REQ-022 SHALL ignore cmd_valid outside IDLE; no queueing.
REQ-023 RD_A: mem_mode=1, mem_addr=src_a; RD_B: mem_addr=src_b, op_a <= mem_rdata; CAP_B: op_b <= mem_rdata.
REQ-024 SHALL drive add_a=op_a, add_b=op_b continuously from registers; in ADD, sum register <= add_sum.
REQ-025 WB: mem_we=1, mem_mode=0, mem_addr=dst, mem_wdata=sum register; the only cycle mem_we=1.
REQ-026 DONE: done=1, result <= sum, op_count <= op_count+1 (wraps 0xFFFF -> 0x0000).
REQ-027 SHALL give fixed latency: handshake edge T, done high during cycle T+6; next command accepted at T+7.
REQ-028 SHALL support src_a==src_b, dst equal to either source (writeback follows both reads).
REQ-029 Outside RD_A..WB: mem_we=0, mem_mode=1, mem_addr=0, mem_wdata=0.
REQ-030 result, match, op_count SHALL hold between operations.

Reset
REQ-031 On reset=1 at rising edge: state=IDLE, op_a/op_b/sum/result=0, match=0, done=0, op_count=0.
REQ-032 Reset mid-operation SHALL abort without writeback; mem_we=0 in the cycle after reset sampled.
REQ-033 cmd_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-034 Macro FPSEQ_CHECK_EN defined: CAP_B issues read of cmd_exp, ADD captures expected word, DONE sets match = (sum == expected).
REQ-035 FPSEQ_CHECK_EN undefined: CAP_B issues no read (mem_addr=0), cmd_exp ignored, match tied 0; latency unchanged.

Verification
REQ-036 Mem[22]=0x40B60001, mem[28]=0x40B2041B, adder model; cmd src_a=22, src_b=28, dst=5 -> WB writes adder output to addr 5, done at T+6.
REQ-037 With FPSEQ_CHECK_EN, mem[31]=0x4134020E, cmd_exp=31, adder returns 0x4134020E -> match=1; corrupt mem[31] to 0 -> match=0.
REQ-038 cmd_valid held high for 20 cycles -> exactly 3 handshakes (T, T+7, T+14), op_count=3.
REQ-039 src_a=src_b=dst=7, mem[7]=0x3F800000 -> adder sees 0x3F800000 on both operands, writeback to 7 after both reads.
REQ-040 Reset asserted during ADD -> no mem_we pulse, done stays 0, cmd_ready=1 next cycle, op_count=0.
REQ-041 op_count preset via 65535 operations (or forced) -> next done wraps op_count to 0.
